// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the 7-segment to ASCII stream block.
//   Segment patterns are in gfedcba order (bit 6 = g, bit 0 = a).
//   Contents: segment/ASCII widths, digit and symbol patterns, ASCII
//   constants, FSM state enum.
package seg7_pkg;

   localparam int unsigned SEG_W  = 7;
   localparam int unsigned CHAR_W = 8;

   // Standard decimal digit patterns
   localparam logic [SEG_W-1:0] SEG_0 = 7'b0111111;
   localparam logic [SEG_W-1:0] SEG_1 = 7'b0000110;
   localparam logic [SEG_W-1:0] SEG_2 = 7'b1011011;
   localparam logic [SEG_W-1:0] SEG_3 = 7'b1001111;
   localparam logic [SEG_W-1:0] SEG_4 = 7'b1100110;
   localparam logic [SEG_W-1:0] SEG_5 = 7'b1101101;
   localparam logic [SEG_W-1:0] SEG_6 = 7'b1111101;
   localparam logic [SEG_W-1:0] SEG_7 = 7'b0000111;
   localparam logic [SEG_W-1:0] SEG_8 = 7'b1111111;
   localparam logic [SEG_W-1:0] SEG_9 = 7'b1101111;

   // Symbols
   localparam logic [SEG_W-1:0] SEG_MINUS = 7'b1000000;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

   // Hex letters (only decoded when SEG7_ASCII_HEX_EN is defined)
   localparam logic [SEG_W-1:0] SEG_HEX_A = 7'b1110111;
   localparam logic [SEG_W-1:0] SEG_HEX_B = 7'b1111100;
   localparam logic [SEG_W-1:0] SEG_HEX_C = 7'b0111001;
   localparam logic [SEG_W-1:0] SEG_HEX_D = 7'b1011110;
   localparam logic [SEG_W-1:0] SEG_HEX_E = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_HEX_F = 7'b1110001;

   // ASCII constants
   localparam logic [CHAR_W-1:0] ASCII_ZERO  = 8'h30;
   localparam logic [CHAR_W-1:0] ASCII_SPACE = 8'h20;
   localparam logic [CHAR_W-1:0] ASCII_MINUS = 8'h2D;
   localparam logic [CHAR_W-1:0] ASCII_QMARK = 8'h3F;
   localparam logic [CHAR_W-1:0] ASCII_LF    = 8'h0A;
   localparam logic [CHAR_W-1:0] ASCII_UC_A  = 8'h41;
   localparam logic [CHAR_W-1:0] ASCII_LC_B  = 8'h62;
   localparam logic [CHAR_W-1:0] ASCII_UC_C  = 8'h43;
   localparam logic [CHAR_W-1:0] ASCII_LC_D  = 8'h64;
   localparam logic [CHAR_W-1:0] ASCII_UC_E  = 8'h45;
   localparam logic [CHAR_W-1:0] ASCII_UC_F  = 8'h46;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_TERM = 2'd2
   } state_t;

endpackage

// File: rtl/seg7_ascii_stream_if.sv
// seg7_ascii_stream_if: byte stream with valid/ready handshake.
//   out_data  : ASCII byte          (master -> slave)
//   out_valid : out_data valid      (master -> slave)
//   out_last  : final byte of frame (master -> slave)
//   out_ready : sink accepts byte   (slave -> master)
interface seg7_ascii_stream_if;
   import seg7_pkg::*;

   logic [CHAR_W-1:0] out_data;
   logic              out_valid;
   logic              out_last;
   logic              out_ready;

   modport master (output out_data, output out_valid, output out_last, input out_ready);
   modport slave  (input out_data, input out_valid, input out_last, output out_ready);

endinterface

// File: rtl/seg7_char_decode.sv
// seg7_char_decode: combinational 7-segment pattern to ASCII decoder.
//   pattern   : segment pattern, gfedcba order (active-high)
//   ascii_c   : decoded ASCII character ('?' when undecodable)
//   invalid_c : pattern is not a recognised character
// Macro SEG7_ASCII_HEX_EN: also decode hex letters A b C d E F.
module seg7_char_decode
   import seg7_pkg::*;
(
   input  logic [SEG_W-1:0]  pattern,
   output logic [CHAR_W-1:0] ascii_c,
   output logic              invalid_c
);

   always_comb begin
      ascii_c   = ASCII_QMARK;
      invalid_c = 1'b0;
      case (pattern)
         SEG_0:     ascii_c = ASCII_ZERO;
         SEG_1:     ascii_c = ASCII_ZERO + 8'd1;
         SEG_2:     ascii_c = ASCII_ZERO + 8'd2;
         SEG_3:     ascii_c = ASCII_ZERO + 8'd3;
         SEG_4:     ascii_c = ASCII_ZERO + 8'd4;
         SEG_5:     ascii_c = ASCII_ZERO + 8'd5;
         SEG_6:     ascii_c = ASCII_ZERO + 8'd6;
         SEG_7:     ascii_c = ASCII_ZERO + 8'd7;
         SEG_8:     ascii_c = ASCII_ZERO + 8'd8;
         SEG_9:     ascii_c = ASCII_ZERO + 8'd9;
         SEG_MINUS: ascii_c = ASCII_MINUS;
         SEG_BLANK: ascii_c = ASCII_SPACE;
`ifdef SEG7_ASCII_HEX_EN
         SEG_HEX_A: ascii_c = ASCII_UC_A;
         SEG_HEX_B: ascii_c = ASCII_LC_B;
         SEG_HEX_C: ascii_c = ASCII_UC_C;
         SEG_HEX_D: ascii_c = ASCII_LC_D;
         SEG_HEX_E: ascii_c = ASCII_UC_E;
         SEG_HEX_F: ascii_c = ASCII_UC_F;
`endif
         default:   invalid_c = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg7_ascii_stream.sv
// seg7_ascii_stream: captures NUM_DIGITS 7-segment digits on start and
// streams them as ASCII bytes, most significant digit first, optionally
// followed by a line feed.
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset
//   start   : capture request (accepted only when idle)
//   seg_bus : digit i at [7i+6:7i], gfedcba order
//   stream  : byte stream master (out_data/out_valid/out_last, out_ready)
//   busy    : frame in progress
//   err     : current frame contains an undecodable digit
// Macro SEG7_ASCII_HEX_EN: decoders also accept hex letters A b C d E F.
module seg7_ascii_stream
   import seg7_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned ACTIVE_LOW = 0,
   parameter int unsigned APPEND_NL  = 1
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [SEG_W*NUM_DIGITS-1:0] seg_bus,
   seg7_ascii_stream_if.master         stream,
   output logic                        busy,
   output logic                        err
);

   localparam int unsigned       IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IDX_W-1:0]  IDX_TOP       = IDX_W'(NUM_DIGITS - 1);
   localparam logic              LAST_IS_DIGIT = (APPEND_NL == 0);

   logic [CHAR_W-1:0]     dec_char [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] dec_bad;

   state_t                state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [CHAR_W-1:0]     char_q [NUM_DIGITS];
   logic [CHAR_W-1:0]     char_d [NUM_DIGITS];
   logic [CHAR_W-1:0]     data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  last_q, last_d;
   logic                  busy_q, busy_d;
   logic                  err_q, err_d;
   logic                  xfer;

   // One decoder per digit; polarity fixed before decode
   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
      logic [SEG_W-1:0] pat;
      assign pat = (ACTIVE_LOW != 0) ? ~seg_bus[SEG_W*i +: SEG_W]
                                     :  seg_bus[SEG_W*i +: SEG_W];
      seg7_char_decode u_dec (
         .pattern   (pat),
         .ascii_c   (dec_char[i]),
         .invalid_c (dec_bad[i])
      );
   end

   assign xfer = valid_q && stream.out_ready;

   // Next-state and output logic
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      char_d  = char_q;
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      busy_d  = busy_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               char_d  = dec_char;
               err_d   = |dec_bad;
               data_d  = dec_char[NUM_DIGITS-1];
               valid_d = 1'b1;
               busy_d  = 1'b1;
               idx_d   = IDX_TOP;
               // A single-digit frame without LF ends on its first byte
               last_d  = LAST_IS_DIGIT && (NUM_DIGITS == 1);
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (xfer) begin
               if (idx_q == '0) begin
                  if (APPEND_NL != 0) begin
                     data_d  = ASCII_LF;
                     last_d  = 1'b1;
                     state_d = ST_TERM;
                  end else begin
                     valid_d = 1'b0;
                     busy_d  = 1'b0;
                     last_d  = 1'b0;
                     state_d = ST_IDLE;
                  end
               end else begin
                  idx_d  = idx_q - IDX_W'(1);
                  data_d = char_q[idx_q - IDX_W'(1)];
                  last_d = LAST_IS_DIGIT && (idx_q == IDX_W'(1));
               end
            end
         end
         ST_TERM: begin
            if (xfer) begin
               valid_d = 1'b0;
               busy_d  = 1'b0;
               last_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   // Captured characters; only meaningful while a frame is active
   always_ff @(posedge clk) begin
      char_q <= char_d;
   end

   assign stream.out_data  = data_q;
   assign stream.out_valid = valid_q;
   assign stream.out_last  = last_q;
   assign busy             = busy_q;
   assign err              = err_q;

endmodule

// File: tb/tb_seg7_ascii_stream.sv
// tb_seg7_ascii_stream: scoreboard bench for seg7_ascii_stream.
//   dut  : NUM_DIGITS=4, ACTIVE_LOW=0, APPEND_NL=1
//   dut2 : NUM_DIGITS=1, ACTIVE_LOW=1, APPEND_NL=0
// Expected bytes {last,data} are queued when a frame is launched and
// popped by a negedge monitor on every valid&&ready cycle.
module tb_seg7_ascii_stream;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        start2;
   logic [27:0] seg_bus;
   logic [6:0]  seg2;
   logic        busy, err, busy2, err2;

   int total = 0;
   int bad   = 0;

   logic [8:0]  sb_q [$];
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_data  = '0;
   logic        prev_last  = 1'b0;
   logic [3:0]  rdy_pat    = 4'b1001;

   seg7_ascii_stream_if sif ();
   seg7_ascii_stream_if sif2 ();

   always #5 clk = ~clk;

   seg7_ascii_stream #(.NUM_DIGITS(4), .ACTIVE_LOW(0), .APPEND_NL(1)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .seg_bus (seg_bus),
      .stream  (sif.master),
      .busy    (busy),
      .err     (err)
   );

   seg7_ascii_stream #(.NUM_DIGITS(1), .ACTIVE_LOW(1), .APPEND_NL(0)) dut2 (
      .clk     (clk),
      .rst     (rst),
      .start   (start2),
      .seg_bus (seg2),
      .stream  (sif2.master),
      .busy    (busy2),
      .err     (err2)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] ref_char(input logic [6:0] p);
      case (p)
         7'b0111111: return 8'h30;
         7'b0000110: return 8'h31;
         7'b1011011: return 8'h32;
         7'b1001111: return 8'h33;
         7'b1100110: return 8'h34;
         7'b1101101: return 8'h35;
         7'b1111101: return 8'h36;
         7'b0000111: return 8'h37;
         7'b1111111: return 8'h38;
         7'b1101111: return 8'h39;
         7'b1000000: return 8'h2D;
         7'b0000000: return 8'h20;
`ifdef SEG7_ASCII_HEX_EN
         7'b1110111: return 8'h41;
         7'b1111100: return 8'h62;
         7'b0111001: return 8'h43;
         7'b1011110: return 8'h64;
         7'b1111001: return 8'h45;
         7'b1110001: return 8'h46;
`endif
         default:    return 8'h3F;
      endcase
   endfunction

   // Queue one expected frame; returns the expected err flag
   task automatic push_frame(input logic [27:0] s, output logic e);
      logic [7:0] c;
      e = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         c = ref_char(s[7*i +: 7]);
         if (c == 8'h3F) e = 1'b1;
         sb_q.push_back({1'b0, c});
      end
      sb_q.push_back({1'b1, 8'h0A});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start pulse, then check the t+1 outputs
   task automatic launch(input logic [27:0] s, input string tag);
      logic e;
      tick();
      seg_bus = s;
      push_frame(s, e);
      start = 1'b1;
      tick();
      start = 1'b0;
      @(negedge clk);
      check_eq({tag, "_valid_t1"}, 32'(sif.out_valid), 32'd1);
      check_eq({tag, "_busy_t1"},  32'(busy), 32'd1);
      check_eq({tag, "_err_t1"},   32'(err), 32'(e));
   endtask

   task automatic drain(input int budget, input string tag);
      for (int k = 0; k < budget; k++) begin
         tick();
         if (sb_q.size() == 0 && !sif.out_valid) break;
      end
      @(negedge clk);
      check_eq({tag, "_drained"}, 32'(sb_q.size()), 32'd0);
      check_eq({tag, "_valid_end"}, 32'(sif.out_valid), 32'd0);
      check_eq({tag, "_busy_end"},  32'(busy), 32'd0);
   endtask

   // Scoreboard monitor and stall-stability check
   always @(negedge clk) begin
      logic [8:0] exp;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check_eq("stall_valid", 32'(sif.out_valid), 32'd1);
            check_eq("stall_data",  32'(sif.out_data), 32'(prev_data));
            check_eq("stall_last",  32'(sif.out_last), 32'(prev_last));
         end
         if (sif.out_valid && sif.out_ready) begin
            if (sb_q.size() == 0) begin
               check_eq("extra_byte", 32'(sb_q.size()), 32'd1);
            end else begin
               exp = sb_q.pop_front();
               check_eq("byte", 32'({sif.out_last, sif.out_data}), 32'(exp));
            end
         end
         prev_stall = sif.out_valid && !sif.out_ready;
         prev_data  = sif.out_data;
         prev_last  = sif.out_last;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        e4;
      logic [27:0] s4;
      logic [27:0] seg_a, seg_b;
      seg_a = {7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110};
      seg_b = {7'b0000111, 7'b1111111, 7'b1101111, 7'b0111111};

      rst = 1'b1; start = 1'b0; start2 = 1'b0;
      seg_bus = '0; seg2 = '0;
      sif.out_ready = 1'b0; sif2.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_valid", 32'(sif.out_valid), 32'd0);
      check_eq("rst_last",  32'(sif.out_last), 32'd0);
      check_eq("rst_busy",  32'(busy), 32'd0);
      check_eq("rst_err",   32'(err), 32'd0);
      check_eq("rst_data",  32'(sif.out_data), 32'h00);
      tick();
      rst = 1'b0;

      // Basic frame at full throughput: 5 bytes in exactly 5 cycles
      sif.out_ready = 1'b1;
      launch(seg_a, "basic");
      repeat (5) @(posedge clk);
      @(negedge clk);
      check_eq("basic_drained", 32'(sb_q.size()), 32'd0);
      check_eq("basic_valid_end", 32'(sif.out_valid), 32'd0);
      check_eq("basic_busy_end",  32'(busy), 32'd0);

      // Backpressure with ready pattern 1,0,0,1
      launch(seg_a, "toggle");
      for (int k = 0; k < 60; k++) begin
         sif.out_ready = rdy_pat[k % 4];
         tick();
         if (sb_q.size() == 0 && !sif.out_valid) break;
      end
      sif.out_ready = 1'b1;
      @(negedge clk);
      check_eq("toggle_drained", 32'(sb_q.size()), 32'd0);
      check_eq("toggle_valid_end", 32'(sif.out_valid), 32'd0);

      // Hex letter, stalled start, ignored start and seg_bus changes mid-frame
      s4 = {7'b0000110, 7'b1110111, 7'b0000000, 7'b1000000};
      e4 = (ref_char(7'b1110111) == 8'h3F);
      sif.out_ready = 1'b0;
      launch(s4, "hex");
      tick();
      start = 1'b1;
      seg_bus = seg_b;
      repeat (3) tick();
      start = 1'b0;
      sif.out_ready = 1'b1;
      drain(30, "hex");
      check_eq("hex_err_held", 32'(err), 32'(e4));

      // Clean frame clears err
      launch(seg_b, "clean");
      drain(30, "clean");
      check_eq("clean_err_held", 32'(err), 32'd0);

      // Reset after the second byte transfer aborts the frame
      launch(seg_a, "abort");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      sb_q.delete();
      tick();
      rst = 1'b0;
      @(negedge clk);
      check_eq("abort_valid", 32'(sif.out_valid), 32'd0);
      check_eq("abort_busy",  32'(busy), 32'd0);
      check_eq("abort_last",  32'(sif.out_last), 32'd0);
      repeat (3) tick();

      // Reset wins over start
      rst = 1'b1;
      start = 1'b1;
      tick();
      rst = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check_eq("rstprio_valid", 32'(sif.out_valid), 32'd0);
      check_eq("rstprio_busy",  32'(busy), 32'd0);

      launch(seg_a, "restart");
      drain(30, "restart");

      // start held high: frame B starts the cycle after A's last transfer
      tick();
      seg_bus = seg_a;
      push_frame(seg_a, e4);
      push_frame(seg_b, e4);
      start = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      seg_bus = seg_b;
      repeat (9) @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check_eq("b2b_drained", 32'(sb_q.size()), 32'd0);
      check_eq("b2b_valid_gap", 32'(sif.out_valid), 32'd0);
      tick();
      @(negedge clk);
      check_eq("b2b_valid_after", 32'(sif.out_valid), 32'd0);
      check_eq("b2b_busy_after",  32'(busy), 32'd0);

      // Active-low single-digit instance without LF
      tick();
      seg2 = 7'b1000000;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      @(negedge clk);
      check_eq("al_zero_data",  32'(sif2.out_data), 32'h30);
      check_eq("al_zero_last",  32'(sif2.out_last), 32'd1);
      check_eq("al_zero_valid", 32'(sif2.out_valid), 32'd1);
      check_eq("al_zero_err",   32'(err2), 32'd0);
      @(negedge clk);
      check_eq("al_zero_done",  32'(sif2.out_valid), 32'd0);
      check_eq("al_zero_busy",  32'(busy2), 32'd0);
      tick();
      seg2 = 7'b1111111;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      @(negedge clk);
      check_eq("al_blank_data", 32'(sif2.out_data), 32'h20);
      check_eq("al_blank_last", 32'(sif2.out_last), 32'd1);
      @(negedge clk);
      check_eq("al_blank_done", 32'(sif2.out_valid), 32'd0);

      repeat (2) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seg7_ascii_stream.md
SEG7_ASCII_STREAM -- requirements
Module: seg7_ascii_stream

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of captured digits (1..16).
REQ-002 SHALL have parameter ACTIVE_LOW, default 0; 1 = segment inputs inverted before decode.
REQ-003 SHALL have parameter APPEND_NL, default 1; 1 = emit 0x0A terminator after the digits.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 SHALL have port clk  in  1  rising-edge clock.
REQ-006 SHALL have port rst  in  1  synchronous active-high reset.
REQ-007 SHALL have port start  in  1  capture request.
REQ-008 SHALL have port seg_bus  in  7*NUM_DIGITS  digit i at bits [7i+6:7i], segment order gfedcba (bit 6 = g).
REQ-009 SHALL have port out_data  out  8  ASCII byte.
REQ-010 SHALL have port out_valid  out  1  out_data valid.
REQ-011 SHALL have port out_ready  in  1  sink accepts byte.
REQ-012 SHALL have port out_last  out  1  marks the final byte of a frame.
REQ-013 SHALL have port busy  out  1  frame in progress.
REQ-014 SHALL have port err  out  1  at least one undecodable digit in the current frame.

Function
REQ-015 SHALL implement FSM IDLE -> SEND -> (TERM if APPEND_NL) -> IDLE.
REQ-016 SHALL accept start only in IDLE; start in SEND/TERM is ignored with no effect.
REQ-017 On start accepted at cycle t, SHALL register all digits as decoded ASCII at t and assert out_valid, busy, with the byte for digit NUM_DIGITS-1, at t+1.
REQ-018 SHALL decode: 0111111..1101111 -> 0x30..0x39 (standard 0-9), 1000000 -> 0x2D '-', 0000000 -> 0x20 ' ', any other pattern -> 0x3F '?'.
REQ-019 SHALL transfer a byte only when out_valid && out_ready; out_data/out_last SHALL hold stable while out_valid && !out_ready.
REQ-020 SHALL present the next byte on the cycle after a transfer, with no bubble; full throughput = 1 byte/cycle.
REQ-021 SHALL send digits in order NUM_DIGITS-1 down to 0, then 0x0A if APPEND_NL=1.
REQ-022 SHALL assert out_last with the final byte (0x0A, or digit 0 if APPEND_NL=0).
REQ-023 After the transfer of the out_last byte, SHALL deassert out_valid/busy the next cycle and return to IDLE; start on that same next cycle SHALL be accepted.
REQ-024 SHALL set err at t+1 if any captured digit decoded to '?', hold until the next accepted start, then reflect the new frame.
REQ-025 SHALL ignore seg_bus changes after capture for the rest of the frame.

Reset
REQ-026 rst SHALL force IDLE, out_valid=0, out_last=0, busy=0, err=0, out_data=0x00, within one cycle.
REQ-027 rst mid-frame SHALL abort the frame; remaining bytes SHALL NOT be emitted; rst has priority over start.

Configuration
REQ-028 Macro SEG7_ASCII_HEX_EN defined: SHALL additionally decode 1110111->'A' 0x41, 1111100->'b' 0x62, 0111001->'C' 0x43, 1011110->'d' 0x64, 1111001->'E' 0x45, 1110001->'F' 0x46.
REQ-029 Macro absent: those six patterns SHALL decode to 0x3F and set err.

Structure
REQ-030 SHALL place segment-pattern constants, ASCII constants (space, minus, '?', LF) and the FSM state enum in package seg7_pkg.
REQ-031 SHALL instantiate one combinational sub-module seg7_char_decode (7-bit pattern -> 8-bit ASCII + invalid flag), one per digit, honouring SEG7_ASCII_HEX_EN.

Verification
REQ-032 NUM_DIGITS=4, APPEND_NL=1, out_ready=1, seg_bus={0000110,1011011,1001111,1100110} ('1','2','3','4'), start pulse -> bytes 0x31,0x32,0x33,0x34,0x0A on consecutive cycles from t+1, out_last on 0x0A, err=0.
REQ-033 Same frame, out_ready toggling 1,0,0,1,... -> no byte lost or duplicated; out_data stable during stalls.
REQ-034 Digit pattern 1110111, macro absent -> byte 0x3F and err=1; macro defined -> 0x41 and err=0.
REQ-035 ACTIVE_LOW=1, seg_bus digit = 1000000 (inverted '0') -> byte 0x30; all-ones digit -> 0x20.
REQ-036 rst asserted after second byte transferred -> out_valid=0, busy=0 next cycle; new start then yields the full frame from the first digit.
REQ-037 start held high continuously -> back-to-back frames, each starting the cycle after the previous out_last transfer; seg_bus change mid-frame not reflected until the next frame.
